// File: rtl/decode_pkg.sv
// Shared encodings and control bundle for the RV64 decode stage.
package decode_pkg;

    localparam int XLEN     = 64;
    localparam int NUM_REGS = 32;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       alu_src;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       branch;
    } ctrl_t;

endpackage

// File: rtl/reg_file.sv
// 32 x 64 register file: two combinational read ports with write-through, one
// write port, x0 hardwired to zero, synchronous clear.
module reg_file
    import decode_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            wr_en,
    input  logic [4:0]      wr_addr,
    input  logic [XLEN-1:0] wr_data
);

    logic [XLEN-1:0] regs_q [NUM_REGS];
    logic            wr_active;

    assign wr_active = wr_en && (wr_addr != 5'd0);

    // Storage update: clear on reset, otherwise accept write-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_active) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    // Read ports; a same-cycle write to the same register is forwarded.
    always_comb begin
        rs1_data = regs_q[rs1_addr];
        rs2_data = regs_q[rs2_addr];
        if (rs1_addr == 5'd0) begin
            rs1_data = '0;
        end else if (wr_active && (wr_addr == rs1_addr)) begin
            rs1_data = wr_data;
        end
        if (rs2_addr == 5'd0) begin
            rs2_data = '0;
        end else if (wr_active && (wr_addr == rs2_addr)) begin
            rs2_data = wr_data;
        end
    end

endmodule

// File: rtl/instruction_decode.sv
// RV64 decode stage: instruction decode, register read, load-use hazard
// detection and the ID/EX pipeline register.
module instruction_decode
    import decode_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [63:0]     id_pc,
    input  logic [31:0]     id_instr,
    input  logic            flush,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [63:0]     wb_data,
    output logic            stall,
    output logic            ex_valid,
    output logic            ex_illegal,
    output logic [63:0]     ex_pc,
    output logic [63:0]     ex_rs1_data,
    output logic [63:0]     ex_rs2_data,
    output logic [63:0]     ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [3:0]      ex_alu_op,
    output logic            ex_alu_src,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_reg_write,
    output logic            ex_mem_to_reg,
    output logic            ex_branch
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1, rs2, rd;
    logic [63:0] rs1_data, rs2_data;
    logic [63:0] imm;
    ctrl_t       ctrl;
    logic        illegal;
    logic        uses_rs2;

    assign opcode = id_instr[6:0];
    assign rd     = id_instr[11:7];
    assign funct3 = id_instr[14:12];
    assign rs1    = id_instr[19:15];
    assign rs2    = id_instr[24:20];
    assign funct7 = id_instr[31:25];

    reg_file u_reg_file (
        .clk      (clk),
        .rst      (rst),
        .rs1_addr (rs1),
        .rs2_addr (rs2),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .wr_en    (wb_en),
        .wr_addr  (wb_rd),
        .wr_data  (wb_data)
    );

    // Decode opcode/funct fields into control bits and immediate.
    always_comb begin
        ctrl     = '0;
        illegal  = 1'b0;
        imm      = '0;
        uses_rs2 = 1'b0;
        case (opcode)
            OP_R: begin
                uses_rs2       = 1'b1;
                ctrl.reg_write = 1'b1;
                if (funct3 == 3'b000 && funct7 == 7'b0000000) begin
                    ctrl.alu_op = ALU_ADD;
                end else if (funct3 == 3'b000 && funct7 == 7'b0100000) begin
                    ctrl.alu_op = ALU_SUB;
                end else if (funct3 == 3'b111 && funct7 == 7'b0000000) begin
                    ctrl.alu_op = ALU_AND;
                end else if (funct3 == 3'b110 && funct7 == 7'b0000000) begin
                    ctrl.alu_op = ALU_OR;
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_IMM: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_ADD;
                imm            = {{52{id_instr[31]}}, id_instr[31:20]};
                illegal        = (funct3 != 3'b000);
            end
            OP_LOAD: begin
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.alu_op     = ALU_ADD;
                imm             = {{52{id_instr[31]}}, id_instr[31:20]};
                illegal         = (funct3 != 3'b011);
            end
            OP_STORE: begin
                uses_rs2       = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_ADD;
                imm            = {{52{id_instr[31]}}, id_instr[31:25], id_instr[11:7]};
                illegal        = (funct3 != 3'b011);
            end
            OP_BRANCH: begin
                uses_rs2    = 1'b1;
                ctrl.branch = 1'b1;
                ctrl.alu_op = ALU_SUB;
                imm         = {{51{id_instr[31]}}, id_instr[31], id_instr[7],
                               id_instr[30:25], id_instr[11:8], 1'b0};
                illegal     = (funct3 != 3'b000);
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
        // Illegal encodings carry no control and never read rs2 for hazards.
        if (illegal) begin
            ctrl     = '0;
            imm      = '0;
            uses_rs2 = 1'b0;
        end
    end

    // Load-use hazard against the instruction currently in ID/EX.
    always_comb begin
        stall = id_valid && !flush && ex_valid && ex_mem_read && (ex_rd != 5'd0) &&
                ((ex_rd == rs1) || (uses_rs2 && (ex_rd == rs2)));
    end

    // ID/EX register: reset, flush, stall and empty IF/ID all insert a bubble.
    always_ff @(posedge clk) begin
        if (rst || flush || stall || !id_valid) begin
            ex_valid      <= 1'b0;
            ex_illegal    <= 1'b0;
            ex_pc         <= '0;
            ex_rs1_data   <= '0;
            ex_rs2_data   <= '0;
            ex_imm        <= '0;
            ex_rs1        <= '0;
            ex_rs2        <= '0;
            ex_rd         <= '0;
            ex_alu_op     <= '0;
            ex_alu_src    <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_branch     <= 1'b0;
        end else begin
            ex_valid      <= 1'b1;
            ex_illegal    <= illegal;
            ex_pc         <= id_pc;
            ex_rs1_data   <= rs1_data;
            ex_rs2_data   <= rs2_data;
            ex_imm        <= imm;
            ex_rs1        <= rs1;
            ex_rs2        <= rs2;
            ex_rd         <= rd;
            ex_alu_op     <= ctrl.alu_op;
            ex_alu_src    <= ctrl.alu_src;
            ex_mem_read   <= ctrl.mem_read;
            ex_mem_write  <= ctrl.mem_write;
            ex_reg_write  <= ctrl.reg_write;
            ex_mem_to_reg <= ctrl.mem_to_reg;
            ex_branch     <= ctrl.branch;
        end
    end

endmodule

// File: tb/tb_instruction_decode.sv
// Scoreboard bench for instruction_decode: driver pushes the expected ID/EX
// contents, a monitor pops and compares one entry per clock.
module tb_instruction_decode;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid = 1'b0;
    logic [63:0] id_pc = '0;
    logic [31:0] id_instr = '0;
    logic        flush = 1'b0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [63:0] wb_data = '0;
    logic        stall;
    logic        ex_valid, ex_illegal;
    logic [63:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [3:0]  ex_alu_op;
    logic        ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch;

    instruction_decode dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (id_valid),
        .id_pc         (id_pc),
        .id_instr      (id_instr),
        .flush         (flush),
        .wb_en         (wb_en),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .stall         (stall),
        .ex_valid      (ex_valid),
        .ex_illegal    (ex_illegal),
        .ex_pc         (ex_pc),
        .ex_rs1_data   (ex_rs1_data),
        .ex_rs2_data   (ex_rs2_data),
        .ex_imm        (ex_imm),
        .ex_rs1        (ex_rs1),
        .ex_rs2        (ex_rs2),
        .ex_rd         (ex_rd),
        .ex_alu_op     (ex_alu_op),
        .ex_alu_src    (ex_alu_src),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_to_reg (ex_mem_to_reg),
        .ex_branch     (ex_branch)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid, illegal;
        logic [3:0]  alu_op;
        logic        alu_src, mem_read, mem_write, reg_write, mem_to_reg, branch;
        logic [63:0] pc, rs1_data, rs2_data, imm;
        logic [4:0]  rs1, rs2, rd;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          passed = 0;
    logic [63:0] mdl_rf [32];
    logic        m_ex_valid = 1'b0, m_ex_load = 1'b0;
    logic [4:0]  m_ex_rd = '0;
    logic        last_stall = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Instruction class: 0 add 1 sub 2 and 3 or 4 addi 5 ld 6 sd 7 beq, -1 illegal.
    function automatic int kind_of(input logic [31:0] ins);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        op = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[31:25];
        if (op == 7'h33 && f3 == 3'd0 && f7 == 7'h00) return 0;
        if (op == 7'h33 && f3 == 3'd0 && f7 == 7'h20) return 1;
        if (op == 7'h33 && f3 == 3'd7 && f7 == 7'h00) return 2;
        if (op == 7'h33 && f3 == 3'd6 && f7 == 7'h00) return 3;
        if (op == 7'h13 && f3 == 3'd0) return 4;
        if (op == 7'h03 && f3 == 3'd3) return 5;
        if (op == 7'h23 && f3 == 3'd3) return 6;
        if (op == 7'h63 && f3 == 3'd0) return 7;
        return -1;
    endfunction

    function automatic logic reads_rs2(input int k);
        return k inside {0, 1, 2, 3, 6, 7};
    endfunction

    function automatic logic [63:0] rf_read(input logic [4:0] idx);
        if (idx == 5'd0) return 64'd0;
        if (wb_en && wb_rd == idx) return wb_data;
        return mdl_rf[idx];
    endfunction

    function automatic exp_t decode_model(input logic [31:0] ins, input logic [63:0] pc,
                                          input int k);
        exp_t             e;
        logic signed [11:0] i12;
        logic signed [12:0] i13;
        e = '{default: '0};
        e.valid = 1'b1;
        e.pc    = pc;
        if (k < 0) begin
            e.illegal = 1'b1;
            return e;
        end
        e.rs1        = ins[19:15];
        e.rs2        = ins[24:20];
        e.rd         = ins[11:7];
        e.rs1_data   = rf_read(e.rs1);
        e.rs2_data   = rf_read(e.rs2);
        e.reg_write  = (k <= 5);
        e.alu_src    = k inside {4, 5, 6};
        e.mem_read   = (k == 5);
        e.mem_to_reg = (k == 5);
        e.mem_write  = (k == 6);
        e.branch     = (k == 7);
        case (k)
            1, 7:    e.alu_op = 4'd1;
            2:       e.alu_op = 4'd2;
            3:       e.alu_op = 4'd3;
            default: e.alu_op = 4'd0;
        endcase
        case (k)
            4, 5: begin i12 = ins[31:20]; e.imm = longint'(i12); end
            6:    begin i12 = {ins[31:25], ins[11:7]}; e.imm = longint'(i12); end
            7:    begin i13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
                        e.imm = longint'(i13); end
            default: e.imm = 64'd0;
        endcase
        return e;
    endfunction

    // One pipeline cycle: drive, check stall, push expected ID/EX, advance the model.
    task automatic step(input logic r, input logic v, input logic [63:0] pc,
                        input logic [31:0] ins, input logic f, input logic we,
                        input logic [4:0] wrd, input logic [63:0] wd);
        exp_t e;
        int   k;
        logic st;
        @(negedge clk);
        rst = r; id_valid = v; id_pc = pc; id_instr = ins; flush = f;
        wb_en = we; wb_rd = wrd; wb_data = wd;
        #1;
        k  = kind_of(ins);
        st = v && !f && m_ex_valid && m_ex_load && (m_ex_rd != 5'd0) &&
             ((m_ex_rd == ins[19:15]) || (reads_rs2(k) && (m_ex_rd == ins[24:20])));
        if (!r) chk("stall", {63'd0, stall}, {63'd0, st});
        e = '{default: '0};
        if (!r && !f && !st && v) e = decode_model(ins, pc, k);
        exp_q.push_back(e);
        last_stall = st && !r;
        m_ex_valid = e.valid;
        m_ex_load  = e.mem_read;
        m_ex_rd    = e.rd;
        if (r) begin
            for (int i = 0; i < 32; i++) mdl_rf[i] = 64'd0;
        end else if (we && wrd != 5'd0) begin
            mdl_rf[wrd] = wd;
        end
    endtask

    // Monitor: compare ID/EX outputs one cycle after each driven cycle.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("ex_valid", {63'd0, ex_valid}, {63'd0, mon_e.valid});
            chk("ex_illegal", {63'd0, ex_illegal}, {63'd0, mon_e.illegal});
            chk("ex_alu_op", {60'd0, ex_alu_op}, {60'd0, mon_e.alu_op});
            chk("ex_ctrl",
                {58'd0, ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg,
                 ex_branch},
                {58'd0, mon_e.alu_src, mon_e.mem_read, mon_e.mem_write, mon_e.reg_write,
                 mon_e.mem_to_reg, mon_e.branch});
            chk("ex_pc", ex_pc, mon_e.pc);
            if (!mon_e.illegal) begin
                chk("ex_rs1", {59'd0, ex_rs1}, {59'd0, mon_e.rs1});
                chk("ex_rs2", {59'd0, ex_rs2}, {59'd0, mon_e.rs2});
                chk("ex_rd", {59'd0, ex_rd}, {59'd0, mon_e.rd});
                chk("ex_rs1_data", ex_rs1_data, mon_e.rs1_data);
                chk("ex_rs2_data", ex_rs2_data, mon_e.rs2_data);
                chk("ex_imm", ex_imm, mon_e.imm);
            end
        end
    end

    function automatic logic [31:0] rand_instr();
        logic [4:0]  r1, r2, rdi;
        logic [11:0] im;
        r1  = 5'($urandom_range(0, 7));
        r2  = 5'($urandom_range(0, 7));
        rdi = 5'($urandom_range(0, 7));
        im  = 12'($urandom);
        case ($urandom_range(0, 9))
            0:       return {7'h00, r2, r1, 3'd0, rdi, 7'h33};
            1:       return {7'h20, r2, r1, 3'd0, rdi, 7'h33};
            2:       return {7'h00, r2, r1, 3'd7, rdi, 7'h33};
            3:       return {7'h00, r2, r1, 3'd6, rdi, 7'h33};
            4:       return {im, r1, 3'd0, rdi, 7'h13};
            5, 6:    return {im, r1, 3'd3, rdi, 7'h03};
            7:       return {im[11:5], r2, r1, 3'd3, im[4:0], 7'h23};
            8:       return {im[11:5], r2, r1, 3'd0, im[4:0], 7'h63};
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic        v;
        logic [31:0] ins;
        logic [63:0] pc;
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        // addi x1,x0,5
        step(0, 1, 64'h100, 32'h00500093, 0, 0, 0, 0);
        // add x3,x2,x2 with write-through of x2
        step(0, 1, 64'h104, 32'h002101B3, 0, 1, 5'd2, 64'hDEAD);
        // ld x5,0(x1) then add x6,x5,x5: one stall, inputs held, then issue
        step(0, 1, 64'h108, 32'h0000B283, 0, 0, 0, 0);
        step(0, 1, 64'h10C, 32'h00528333, 0, 0, 0, 0);
        step(0, 1, 64'h10C, 32'h00528333, 0, 0, 0, 0);
        // write-back to x0 ignored, then add x3,x0,x0
        step(0, 1, 64'h110, 32'h00000013, 0, 1, 5'd0, 64'hFF);
        step(0, 1, 64'h114, 32'h000001B3, 0, 0, 0, 0);
        // flush coinciding with a pending load-use stall
        step(0, 1, 64'h118, 32'h0000B283, 0, 0, 0, 0);
        step(0, 1, 64'h11C, 32'h00528333, 1, 0, 0, 0);
        // illegal and sub
        step(0, 1, 64'h120, 32'hFFFFFFFF, 0, 0, 0, 0);
        step(0, 1, 64'h124, 32'h40528333, 0, 0, 0, 0);
        // reset while a load-use stall is pending
        step(0, 1, 64'h128, 32'h0000B283, 0, 0, 0, 0);
        step(1, 1, 64'h12C, 32'h00528333, 0, 0, 0, 0);
        step(0, 1, 64'h12C, 32'h00528333, 0, 0, 0, 0);

        v   = 1'b0;
        ins = 32'd0;
        pc  = 64'h1000;
        for (int n = 0; n < 600; n++) begin
            if (!last_stall) begin
                v   = ($urandom_range(0, 9) != 0);
                ins = rand_instr();
                pc  = pc + 64'd4;
            end
            step(($urandom_range(0, 99) == 0), v, pc, ins, ($urandom_range(0, 9) == 0),
                 1'($urandom), 5'($urandom_range(0, 7)), {$urandom, $urandom});
        end
        step(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/instruction_decode.md
# instruction_decode

Decode stage of the 5-stage RV64 pipeline, between the IF/ID register and execute. Decodes the IF/ID instruction and reads a 32×64 register file that has a write-back port and same-cycle write-through. Detects load-use hazards against its own ID/EX register. Registers control, operands and immediate into the ID/EX pipeline register.

## Interface
- No parameters. Opcode and ALU-op encodings are fixed constants in the shared package.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  IF/ID holds a real instruction
- id_pc  in  64  PC from IF/ID
- id_instr  in  32  instruction from IF/ID
- flush  in  1  branch-taken squash from execute
- wb_en  in  1  write-back enable
- wb_rd  in  5  write-back destination register
- wb_data  in  64  write-back data
- stall  out  1  hold PC and IF/ID this cycle (combinational)
- ex_valid, ex_illegal  out  1 each  ID/EX entry valid; undecodable instruction
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  64 each  registered PC, operands, sign-extended immediate
- ex_rs1, ex_rs2, ex_rd  out  5 each  register indices, kept for forwarding
- ex_alu_op  out  4  ALU_ADD=0, ALU_SUB=1, ALU_AND=2, ALU_OR=3
- ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch  out  1 each  control bits

## Operation
- Supported instructions:
  - R-type 0110011: add (f3=000, f7=0000000), sub (f3=000, f7=0100000), and (f3=111, f7=0), or (f3=110, f7=0).
  - addi: opcode 0010011, f3=000.
  - ld: opcode 0000011, f3=011.
  - sd: opcode 0100011, f3=011.
  - beq: opcode 1100011, f3=000.
- Any other encoding gives ex_illegal=1 and ex_valid=1. All control bits and ex_alu_op are 0 for an illegal instruction.
- Immediates, all sign-extended from instr[31] to 64 bits:
  - I-type: instr[31:20].
  - S-type: {instr[31:25], instr[11:7]}.
  - B-type: {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - R-type: 0.
- Control per instruction:
  - R-type: reg_write.
  - addi: reg_write, alu_src, ADD.
  - ld: reg_write, alu_src, mem_read, mem_to_reg, ADD.
  - sd: mem_write, alu_src, ADD.
  - beq: branch, SUB.
- Register file:
  - x0 always reads 0.
  - A write occurs on the clock edge when wb_en=1 and wb_rd≠0.
  - Reads are combinational with write-through: if wb_en=1, wb_rd≠0 and wb_rd equals the rs index, the read returns wb_data.
- Load-use hazard: stall=1 when all of the following hold:
  - id_valid=1 and flush=0;
  - ex_valid=1, ex_mem_read=1 and ex_rd≠0;
  - ex_rd equals rs1, or equals rs2 of an R-type, sd or beq.
- ID/EX update priority on each edge:
  1. rst: all outputs cleared.
  2. flush: bubble.
  3. stall: bubble.
  4. Otherwise: load the decoded id_valid instruction.
- A bubble means ex_valid=0 with all control bits, ex_illegal and ex_alu_op at 0. The data fields of a bubble are don't-care but are driven 0.
- When id_valid=0, the stage loads a bubble.

## Timing
- Latency: 1 cycle from IF/ID outputs to ID/EX outputs.
- stall is combinational from id_instr, id_valid, flush and ID/EX state. A load-use stall lasts exactly 1 cycle.
- Reset values:
  - All ex_* outputs are 0.
  - stall is 0 after reset because ex_valid=0.
  - All 32 registers are cleared to 0.
- Simultaneous events:
  - flush and stall in the same cycle: flush wins and stall is driven 0.
  - Write-back and read of the same register in the same cycle: the new data is read.
  - Write-back to x0: ignored.
- rst mid-stall: the next cycle has ex_valid=0 and stall=0. Register file contents are lost.

## Structure
- Package decode_pkg holds:
  - opcode constants: OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH;
  - ALU_* constants;
  - a packed struct ctrl_t containing the six control bits and alu_op.
- Sub-module reg_file: 32×64, two combinational read ports, one write port, write-through, synchronous clear.
- Decoder logic, hazard logic and the ID/EX register live in instruction_decode.

## Test plan
- Decode addi: id_valid=1, id_instr=0x00500093 (addi x1,x0,5). Next cycle requires ex_valid=1, ex_rd=1, ex_imm=5, ex_alu_src=1, ex_reg_write=1, ex_alu_op=ALU_ADD.
- Write-through: wb_en=1, wb_rd=2, wb_data=0xDEAD, with id_instr=0x002101B3 (add x3,x2,x2) in the same cycle. Next cycle requires ex_rs1_data=ex_rs2_data=0xDEAD.
- Load-use stall:
  - Stimulus: 0x0000B283 (ld x5,0(x1)) followed by 0x00528333 (add x6,x5,x5).
  - Required: stall=1 for exactly 1 cycle, with the IF/ID inputs held during the stall.
  - Required: ID/EX carries a bubble (ex_valid=0) for that cycle.
  - Required: on the following cycle, the add is issued with ex_rd=6.
- x0 write: wb_en=1, wb_rd=0, wb_data=0xFF, then add x3,x0,x0. Requires ex_rs1_data=0.
- Flush priority: flush=1 in the same cycle as a pending load-use stall. Requires stall=0 and ex_valid=0 next cycle.
- Illegal and sub: id_instr=0xFFFFFFFF requires ex_illegal=1 with all control bits 0. id_instr=0x40528333 (sub) requires ex_alu_op=ALU_SUB.
